rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one datapath resource (for example an encoder or estimator slice) among four clients.
- Issues a registered one-hot grant and its 2-bit encoded index, using the same encoding as the 4:2 encoder.
- Enforces a one-cycle turnaround between owners and an optional maximum hold time with preemption.
- Keeps per-requester grant counters that the power-estimation logic reads.

Parameters:
- MAX_HOLD, 16, max consecutive cycles one owner may hold the grant while others wait; 0 disables preemption.
- CNT_W, 16, width of each per-requester grant counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines, bit i = requester i, level-sensitive.
- release  input  1  single-cycle pulse from the current owner ending its grant.
- clr_counts  input  1  synchronous clear of all grant counters.
- cnt_sel  input  2  selects which counter drives gnt_count.
- gnt  output  4  one-hot grant, registered.
- gnt_idx  output  2  encoded index of gnt: 0001->0, 0010->1, 0100->2, 1000->3; 0 when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- preempt  output  1  one-cycle pulse marking a forced grant termination.
- gnt_count  output  CNT_W  combinational read of counter[cnt_sel].

Behaviour:
- Reset (rst_n low, asynchronous):
  - gnt=0000, gnt_idx=0, gnt_valid=0, preempt=0.
  - All counters=0, hold counter=0.
  - Priority pointer=0 (requester 0 highest).
  - State=IDLE.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Arbitration is evaluated combinationally each cycle.
  - Winner is the first asserted req bit scanning pointer, pointer+1, … (mod 4).
  - If any req is high at edge N, gnt/gnt_idx/gnt_valid are set after edge N and state=GRANT. Latency from req to gnt is 1 cycle.
  - If no req is high, stay in IDLE with outputs at 0.
- Entering GRANT:
  - Hold counter loads 1.
  - counter[winner] increments, saturating at 2^CNT_W-1.
- GRANT: the hold counter increments each cycle, saturating. Exit to GAP at the edge where any of these holds:
  - (a) release=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD!=0, the hold counter equals MAX_HOLD, and some other req bit is high.
- Timeout with no other requester pending: no exit, no preempt, hold counter stays saturated at MAX_HOLD.
- preempt=1 only when (c) causes the exit and neither (a) nor (b) holds. It is high during the GAP cycle.
- On any exit from GRANT:
  - pointer = gnt_idx+1 mod 4.
  - gnt, gnt_idx and gnt_valid clear after the edge.
- GAP:
  - Exactly one cycle with gnt=0. preempt deasserts after it.
  - Arbitration is evaluated during GAP. If any req is high, the next grant is issued at the edge leaving GAP (goes straight to GRANT); otherwise go to IDLE.
  - Owner-to-owner spacing is therefore exactly one idle cycle.
- Ignored inputs:
  - release while not in GRANT is ignored.
  - req changes during GRANT on non-owner bits only affect the next arbitration.
- clr_counts:
  - Clears all counters at the edge.
  - If it coincides with a grant increment, clear wins and that counter reads 0.
- Reset mid-GRANT drops gnt immediately (asynchronously). No preempt is emitted.

Test Plan:
1. Hold rst_n=0 with random req -> gnt=0000, gnt_idx=0, gnt_valid=0, preempt=0, all gnt_count=0. Release reset with req=0000 -> stays in IDLE.
2. req=0100 from cycle 2, release pulse at cycle 6 -> gnt=0100 and gnt_idx=2 for cycles 3..6, gnt=0000 at cycle 7, count[2]=1 (cnt_sel=2).
3. req=1111 held, owner pulses release 2 cycles after each grant -> grant order 0,1,2,3,0, each separated by one cycle of gnt=0. count[0]=2, count[1..3]=1.
4. MAX_HOLD=4, req[0] held with no release, req[1] raised at cycle 3 -> gnt=0001 for 4 cycles, then preempt=1 for one cycle with gnt=0000, then gnt=0010. Repeat with req[1]=0 -> gnt=0001 held indefinitely, preempt never pulses.
5. Owner drops req[3] mid-grant, no release -> gnt=0000 on the following cycle, preempt=0, pointer=0. Release coinciding with the timeout condition -> preempt=0.
6. Assert rst_n=0 mid-GRANT -> gnt clears without waiting for clk. Assert clr_counts on the same edge as a grant to requester 1 -> count[1]=0 afterwards.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with turnaround gap, hold-time preemption and grant counters
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req[3:0]      level-sensitive requests, bit i = requester i
//   release_pulse single-cycle pulse from the current owner ending its grant
//   clr_counts    synchronous clear of all grant counters
//   cnt_sel[1:0]  selects which grant counter drives gnt_count
//   gnt[3:0]      registered one-hot grant
//   gnt_idx[1:0]  encoded index of gnt, 0 when no grant
//   gnt_valid     high while any grant is active
//   preempt       one-cycle pulse during the gap that follows a forced termination
//   gnt_count     combinational read of the selected grant counter

module rr_arbiter4 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic             release_pulse,
    input  logic             clr_counts,
    input  logic [1:0]       cnt_sel,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic             preempt,
    output logic [CNT_W-1:0] gnt_count
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
    // With preemption disabled the hold counter just saturates at all-ones.
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD != 0) ? HOLD_W'(MAX_HOLD) : {HOLD_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [3:0]        gnt_n;
    logic [1:0]        idx_n;
    logic              preempt_n;
    logic [1:0]        ptr, ptr_n;
    logic [HOLD_W-1:0] hold, hold_n;
    logic [CNT_W-1:0]  cnt [4];

    logic [1:0]        win;
    logic              any_req;
    logic [1:0]        cand;
    logic              grant_en;
    logic              timeout;
    logic              owner_drop;

    // Rotating priority scan starting at the pointer.
    always_comb begin
        win     = ptr;
        any_req = 1'b0;
        cand    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!any_req && req[cand]) begin
                win     = cand;
                any_req = 1'b1;
            end
        end
    end

    assign owner_drop = !req[gnt_idx];
    assign timeout    = (MAX_HOLD != 0) && (hold == HOLD_W'(MAX_HOLD)) && ((req & ~gnt) != 4'b0000);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        idx_n     = gnt_idx;
        preempt_n = 1'b0;
        ptr_n     = ptr;
        hold_n    = hold;
        grant_en  = 1'b0;
        case (state)
            IDLE, GAP: begin
                hold_n = '0;
                if (any_req) begin
                    state_n  = GRANT;
                    gnt_n    = 4'b0001 << win;
                    idx_n    = win;
                    hold_n   = HOLD_W'(1);
                    grant_en = 1'b1;
                end else begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    idx_n   = 2'd0;
                end
            end
            GRANT: begin
                if (release_pulse || owner_drop || timeout) begin
                    state_n   = GAP;
                    gnt_n     = 4'b0000;
                    idx_n     = 2'd0;
                    ptr_n     = gnt_idx + 2'd1;
                    hold_n    = '0;
                    // Only a pure timeout counts as a forced termination.
                    preempt_n = timeout && !release_pulse && !owner_drop;
                end else if (hold != HOLD_SAT) begin
                    hold_n = hold + HOLD_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 4'b0000;
                idx_n   = 2'd0;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 4'b0000;
            gnt_idx <= 2'd0;
            preempt <= 1'b0;
            ptr     <= 2'd0;
            hold    <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= idx_n;
            preempt <= preempt_n;
            ptr     <= ptr_n;
            hold    <= hold_n;
        end
    end

    // Clear has priority over a coincident grant increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (clr_counts) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else if (grant_en && (cnt[win] != {CNT_W{1'b1}})) begin
            cnt[win] <= cnt[win] + CNT_W'(1);
        end
    end

    assign gnt_valid = |gnt;
    assign gnt_count = cnt[cnt_sel];

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed self-checking bench for rr_arbiter4

module tb_rr_arbiter4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic        release_pulse;
    logic        clr_counts;
    logic [1:0]  cnt_sel;
    logic [3:0]  gnt;
    logic [1:0]  gnt_idx;
    logic        gnt_valid;
    logic        preempt;
    logic [15:0] gnt_count;

    int checks = 0;
    int errors = 0;

    rr_arbiter4 #(.MAX_HOLD(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .release_pulse (release_pulse),
        .clr_counts    (clr_counts),
        .cnt_sel       (cnt_sel),
        .gnt           (gnt),
        .gnt_idx       (gnt_idx),
        .gnt_valid     (gnt_valid),
        .preempt       (preempt),
        .gnt_count     (gnt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] i,
                             input logic v, input logic p);
        chk({tag, ".gnt"}, 32'(gnt), 32'(g));
        chk({tag, ".idx"}, 32'(gnt_idx), 32'(i));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
        chk({tag, ".preempt"}, 32'(preempt), 32'(p));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        release_pulse = 1'b0;
        clr_counts = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_cnt [4];
        logic [3:0] exp_g;

        // 1. reset with random requests
        rst_n = 1'b0;
        req = 4'($urandom);
        release_pulse = 1'b0;
        clr_counts = 1'b0;
        cnt_sel = 2'd0;
        tick();
        tick();
        chk_grant("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            chk($sformatf("rst.cnt%0d", i), 32'(gnt_count), 32'd0);
        end
        rst_n = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        chk_grant("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 2. single requester 2, release after four grant cycles
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_grant($sformatf("t2.c%0d", c), 4'b0100, 2'd2, 1'b1, 1'b0);
            if (c == 3) release_pulse = 1'b1;
        end
        tick();
        release_pulse = 1'b0;
        req = 4'b0000;
        chk_grant("t2.gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        cnt_sel = 2'd2;
        #1;
        chk("t2.cnt2", 32'(gnt_count), 32'd1);
        tick();
        chk_grant("t2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // 3. all requesting, owner releases after two cycles: 0,1,2,3,0
        pulse_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            chk_grant($sformatf("t3.g%0d", k), exp_g, 2'(k % 4), 1'b1, 1'b0);
            tick();
            chk($sformatf("t3.hold%0d", k), 32'(gnt), 32'(exp_g));
            release_pulse = 1'b1;
            if (k == 4) req = 4'b0000;
            tick();
            release_pulse = 1'b0;
            chk_grant($sformatf("t3.gap%0d", k), 4'b0000, 2'd0, 1'b0, 1'b0);
            if (k < 4) tick();
        end
        exp_cnt[0] = 16'd2;
        exp_cnt[1] = 16'd1;
        exp_cnt[2] = 16'd1;
        exp_cnt[3] = 16'd1;
        for (int i = 0; i < 4; i++) begin
            cnt_sel = 2'(i);
            #1;
            chk($sformatf("t3.cnt%0d", i), 32'(gnt_count), 32'(exp_cnt[i]));
        end
        tick();

        // 4. preemption after MAX_HOLD=4 cycles when requester 1 waits
        pulse_reset();
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk_grant($sformatf("t4.own0.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
            if (c == 1) req = 4'b0011;
        end
        tick();
        chk_grant("t4.preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_grant("t4.own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        chk_grant("t4.drop1", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        // 4b. requester 0 alone holds indefinitely, no preempt
        req = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_grant($sformatf("t4.hold.c%0d", c), 4'b0001, 2'd0, 1'b1, 1'b0);
        end

        // 5b. release coinciding with timeout: no preempt
        req = 4'b0101;
        release_pulse = 1'b1;
        tick();
        release_pulse = 1'b0;
        req = 4'b0000;
        chk_grant("t5.rel_timeout", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();

        // 5. owner 3 drops its request mid-grant; pointer wraps to 0
        req = 4'b1000;
        tick();
        chk_grant("t5.own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        tick();
        req = 4'b0000;
        tick();
        chk_grant("t5.drop3", 4'b0000, 2'd0, 1'b0, 1'b0);
        tick();
        req = 4'b1111;
        tick();
        chk_grant("t5.ptr0", 4'b0001, 2'd0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
        tick();

        // 6. asynchronous reset mid-grant
        req = 4'b0010;
        tick();
        chk_grant("t6.own1", 4'b0010, 2'd1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_grant("t6.async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0000;
        #1;
        rst_n = 1'b1;

        // 6b. clear coinciding with a grant to requester 1
        tick();
        req = 4'b0010;
        clr_counts = 1'b1;
        tick();
        clr_counts = 1'b0;
        cnt_sel = 2'd1;
        #1;
        chk_grant("t6.clr_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        chk("t6.cnt1", 32'(gnt_count), 32'd0);
        req = 4'b0000;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
